midi_uart: RTL and testbench

Parametrised MIDI serial port for the SAM Coupé core, replacing the timing-only MIDI model in the top level (port 253) with a real UART. It has a TX FIFO and a serialiser, plus a deserialiser with an RX FIFO. Line timing comes from the system 1 MHz clock enable (`ce_1m`). The ASIC port decoder feeds it single-cycle write/read strobes, and its interrupt outputs drive the STATUS port bits and `nINT`.

---
 rtl/midi_uart.sv | 256 +++++++++++++++++++++++++
 tb/tb_midi_uart.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | midi_uart : MIDI UART with TX/RX FIFOs, bit timing from a tick ce  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module midi_uart #(
  parameter int DEPTH     = 4,
  parameter int BIT_TICKS = 32,
  parameter int INT_LEAD  = 15
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       int_tx,
  output logic       int_rx,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_ferr
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(10 * BIT_TICKS);
  localparam int TW = $clog2(BIT_TICKS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(10 * BIT_TICKS - 1);
  localparam logic [FW-1:0] LEAD       = FW'(INT_LEAD);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(BIT_TICKS / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // TX side
  logic [7:0]    txm_q [DEPTH];
  logic [7:0]    txm_d [DEPTH];
  logic [AW:0]   txw_q, txw_d, txr_q, txr_d;
  state_t        tx_st_q, tx_st_d;
  logic [TW-1:0] tx_tick_q, tx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_line_q, tx_line_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          int_tx_q, int_tx_d;
  logic          tx_load, tx_push, tx_empty, tx_full_c;

  // RX side
  logic [7:0]    rxm_q [DEPTH];
  logic [7:0]    rxm_d [DEPTH];
  logic [AW:0]   rxw_q, rxw_d, rxr_q, rxr_d;
  state_t        rx_st_q, rx_st_d;
  logic [TW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          rx_push, rx_pop, ovr_set, ferr_set, rx_empty, rx_full, rx_fall;

  assign tx_empty  = (txw_q == txr_q);
  assign tx_full_c = (txw_q[AW] != txr_q[AW]) && (txw_q[AW-1:0] == txr_q[AW-1:0]);
  // A pop in the same cycle frees the slot the write lands in
  assign tx_push   = wr && (!tx_full_c || tx_load);

  assign rx_empty  = (rxw_q == rxr_q);
  assign rx_full   = (rxw_q[AW] != rxr_q[AW]) && (rxw_q[AW-1:0] == rxr_q[AW-1:0]);
  assign rx_pop    = rd && !rx_empty;
  assign rx_fall   = rx_s3_q && !rx_s2_q;

  assign tx         = tx_line_q;
  assign int_tx     = int_tx_q;
  assign tx_full    = tx_full_c;
  assign tx_busy    = (tx_st_q != S_IDLE) || !tx_empty;
  assign int_rx     = !rx_empty;
  assign rx_overrun = ovr_q;
  assign rx_ferr    = ferr_q;
  assign dout       = rx_empty ? 8'hFF : rxm_q[rxr_q[AW-1:0]];

  always_comb begin : tx_fifo
    txm_d = txm_q;
    txw_d = txw_q;
    txr_d = txr_q;
    if (tx_push) begin
      txm_d[txw_q[AW-1:0]] = din;
      txw_d = txw_q + 1'b1;
    end
    if (tx_load) txr_d = txr_q + 1'b1;
  end

  always_comb begin : tx_fsm
    tx_st_d   = tx_st_q;
    tx_tick_d = tx_tick_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_line_d = tx_line_q;
    frame_d   = frame_q;
    int_tx_d  = int_tx_q;
    tx_load   = 1'b0;
    if (ce && tx_st_q != S_IDLE) begin
      frame_d   = frame_q - 1'b1;
      tx_tick_d = tx_tick_q - 1'b1;
      if (tx_st_q == S_STOP && tx_tick_q == '0) int_tx_d = 1'b0;
      else if (frame_q == LEAD)                 int_tx_d = 1'b1;
    end
    if (ce) begin
      case (tx_st_q)
        S_IDLE:  tx_load = !tx_empty;
        S_START: if (tx_tick_q == '0) begin
          tx_line_d = tx_sh_q[0];
          tx_sh_d   = {1'b0, tx_sh_q[7:1]};
          tx_bit_d  = '0;
          tx_tick_d = BIT_LAST;
          tx_st_d   = S_DATA;
        end
        S_DATA: if (tx_tick_q == '0) begin
          tx_tick_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_line_d = 1'b1;
            tx_st_d   = S_STOP;
          end else begin
            tx_line_d = tx_sh_q[0];
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            tx_bit_d  = tx_bit_q + 1'b1;
          end
        end
        S_STOP: if (tx_tick_q == '0) begin
          tx_st_d = S_IDLE;
          tx_load = !tx_empty;
        end
        default: tx_st_d = S_IDLE;
      endcase
    end
    // Popping the head starts a frame; from STOP this chains frames with no gap
    if (tx_load) begin
      tx_sh_d   = txm_q[txr_q[AW-1:0]];
      tx_line_d = 1'b0;
      tx_tick_d = BIT_LAST;
      frame_d   = FRAME_LAST;
      tx_st_d   = S_START;
    end
  end

  always_comb begin : rx_fsm
    rx_st_d   = rx_st_q;
    rx_tick_d = rx_tick_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_push   = 1'b0;
    ovr_set   = 1'b0;
    ferr_set  = 1'b0;
    case (rx_st_q)
      S_IDLE: if (rx_fall) begin
        rx_st_d   = S_START;
        rx_tick_d = HALF_LAST;
      end
      S_START: if (ce) begin
        if (rx_tick_q != '0) rx_tick_d = rx_tick_q - 1'b1;
        else if (rx_s2_q)    rx_st_d = S_IDLE;
        else begin
          rx_st_d   = S_DATA;
          rx_tick_d = BIT_LAST;
          rx_bit_d  = '0;
        end
      end
      S_DATA: if (ce) begin
        if (rx_tick_q != '0) rx_tick_d = rx_tick_q - 1'b1;
        else begin
          rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
          rx_tick_d = BIT_LAST;
          rx_bit_d  = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end
      end
      S_STOP: if (ce) begin
        if (rx_tick_q != '0) rx_tick_d = rx_tick_q - 1'b1;
        else begin
          rx_st_d = S_IDLE;
          if (!rx_s2_q)     ferr_set = 1'b1;
          else if (rx_full) ovr_set  = 1'b1;
          else              rx_push  = 1'b1;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin : rx_fifo
    rxm_d  = rxm_q;
    rxw_d  = rxw_q;
    rxr_d  = rxr_q;
    ovr_d  = ovr_set  ? 1'b1 : (rd ? 1'b0 : ovr_q);
    ferr_d = ferr_set ? 1'b1 : (rd ? 1'b0 : ferr_q);
    if (rx_push) begin
      rxm_d[rxw_q[AW-1:0]] = rx_sh_q;
      rxw_d = rxw_q + 1'b1;
    end
    if (rx_pop) rxr_d = rxr_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        txm_q[i] <= '0;
        rxm_q[i] <= '0;
      end
      txw_q     <= '0;
      txr_q     <= '0;
      tx_st_q   <= S_IDLE;
      tx_tick_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= 1'b1;
      frame_q   <= '0;
      int_tx_q  <= 1'b0;
      rxw_q     <= '0;
      rxr_q     <= '0;
      rx_st_q   <= S_IDLE;
      rx_tick_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      txm_q     <= txm_d;
      rxm_q     <= rxm_d;
      txw_q     <= txw_d;
      txr_q     <= txr_d;
      tx_st_q   <= tx_st_d;
      tx_tick_q <= tx_tick_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_line_q <= tx_line_d;
      frame_q   <= frame_d;
      int_tx_q  <= int_tx_d;
      rxw_q     <= rxw_d;
      rxr_q     <= rxr_d;
      rx_st_q   <= rx_st_d;
      rx_tick_q <= rx_tick_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_uart.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_midi_uart : directed vector bench for midi_uart                 |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_midi_uart;

  localparam int CE_DIV  = 4;
  localparam int BIT_CLK = 32 * CE_DIV;

  logic       clk, rst_n, ce, wr, rd, rx_drv, loop, ce_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       tx, int_tx, int_rx, tx_full, tx_busy, rx_overrun, rx_ferr;
  logic       rx_w;
  int         checks, errors, ce_cnt;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_int;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } rx_vec_t;
  rx_vec_t vecs [6];

  assign rx_w = loop ? tx : rx_drv;

  midi_uart dut (
    .clk_sys(clk), .rst_n(rst_n), .ce(ce), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .rx(rx_w), .tx(tx), .int_tx(int_tx), .int_rx(int_rx),
    .tx_full(tx_full), .tx_busy(tx_busy), .rx_overrun(rx_overrun), .rx_ferr(rx_ferr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce     = 1'b0;
    ce_cnt = 0;
    forever begin
      @(negedge clk);
      if (ce_en) begin
        ce     = (ce_cnt == 0);
        ce_cnt = (ce_cnt == CE_DIV - 1) ? 0 : ce_cnt + 1;
      end else begin
        ce = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_wr(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(BIT_CLK);
    end
    rx_drv = stop;
    tick(BIT_CLK);
    rx_drv = 1'b1;
    tick(2 * BIT_CLK);
  endtask

  task automatic wait_tx_low();
    int n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_start", {31'b0, tx}, 32'd0);
  endtask

  initial begin
    logic [9:0] frame_bits;
    logic [7:0] ovr_bytes [5];
    int         c;

    checks = 0; errors = 0;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    rx_drv = 1'b1; loop = 1'b0; ce_en = 1'b1;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    ovr_bytes[0] = 8'h11; ovr_bytes[1] = 8'h22; ovr_bytes[2] = 8'h33;
    ovr_bytes[3] = 8'h44; ovr_bytes[4] = 8'h55;

    // Reset state
    tick(5);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_flags", {26'b0, int_tx, int_rx, tx_full, tx_busy, rx_overrun, rx_ferr}, 32'd0);
    check("rst_dout", {24'b0, dout}, 32'hFF);
    rst_n = 1'b1;
    tick(5);

    // Single TX frame 0x90 with int_tx window
    do_wr(8'h90);
    check("busy_after_wr", {31'b0, tx_busy}, 32'd1);
    wait_tx_low();
    frame_bits = {1'b1, 8'h90, 1'b0};
    for (c = 1; c <= 1290; c++) begin
      @(negedge clk);
      if (c % BIT_CLK == 64 && c / BIT_CLK < 10)
        check("tx_bit", {31'b0, tx}, {31'b0, frame_bits[c / BIT_CLK]});
      if (c == 1210) check("int_tx_before", {31'b0, int_tx}, 32'd0);
      if (c == 1220) check("int_tx_rise", {31'b0, int_tx}, 32'd1);
      if (c == 1278) check("int_tx_hold", {31'b0, int_tx}, 32'd1);
      if (c == 1286) begin
        check("int_tx_clear", {31'b0, int_tx}, 32'd0);
        check("busy_end", {31'b0, tx_busy}, 32'd0);
        check("tx_idle", {31'b0, tx}, 32'd1);
      end
    end

    // RX vector table
    for (int i = 0; i < 6; i++) begin
      send_rx(vecs[i].data, vecs[i].stop);
      check("rx_int", {31'b0, int_rx}, {31'b0, vecs[i].exp_int});
      check("rx_dout", {24'b0, dout}, {24'b0, vecs[i].exp_dout});
      check("rx_ferr", {31'b0, rx_ferr}, {31'b0, vecs[i].exp_ferr});
      do_rd();
      check("rd_int", {31'b0, int_rx}, 32'd0);
      check("rd_dout", {24'b0, dout}, 32'hFF);
      check("rd_ferr", {31'b0, rx_ferr}, 32'd0);
    end

    // Short glitch is rejected, receiver still works afterwards
    rx_drv = 1'b0;
    tick(10 * CE_DIV);
    rx_drv = 1'b1;
    tick(1400);
    check("glitch_int", {31'b0, int_rx}, 32'd0);
    check("glitch_ferr", {31'b0, rx_ferr}, 32'd0);
    send_rx(8'h81, 1'b1);
    check("post_glitch_dout", {24'b0, dout}, 32'h81);
    do_rd();

    // RX overrun
    for (int i = 0; i < 5; i++) send_rx(ovr_bytes[i], 1'b1);
    check("ovr_flag", {31'b0, rx_overrun}, 32'd1);
    check("ovr_head", {24'b0, dout}, 32'h11);
    do_rd();
    check("ovr_cleared", {31'b0, rx_overrun}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      check("ovr_order", {24'b0, dout}, {24'b0, ovr_bytes[i]});
      do_rd();
    end
    check("ovr_drained", {31'b0, int_rx}, 32'd0);

    // TX FIFO full, drop, back-to-back frames looped to RX
    ce_en = 1'b0;
    tick(2);
    for (int i = 1; i <= 4; i++) do_wr(8'(i));
    check("tx_full_4", {31'b0, tx_full}, 32'd1);
    do_wr(8'h05);
    check("tx_full_5", {31'b0, tx_full}, 32'd1);
    loop  = 1'b1;
    ce_en = 1'b1;
    wait_tx_low();
    check("full_after_pop", {31'b0, tx_full}, 32'd0);
    c = 0;
    while (tx_busy === 1'b1 && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check("b2b_duration", c, 32'd5120);
    tick(300);
    check("b2b_overrun", {31'b0, rx_overrun}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("b2b_byte", {24'b0, dout}, i);
      do_rd();
    end
    check("b2b_drop5", {24'b0, dout}, 32'hFF);

    // Reset mid-frame, then a clean frame
    do_wr(8'hA7);
    wait_tx_low();
    tick(300);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_flags", {26'b0, int_tx, int_rx, tx_full, tx_busy, rx_overrun, rx_ferr}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    do_wr(8'h5A);
    tick(1700);
    check("post_rst_int", {31'b0, int_rx}, 32'd1);
    check("post_rst_dout", {24'b0, dout}, 32'h5A);
    check("post_rst_ferr", {31'b0, rx_ferr}, 32'd0);
    do_rd();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
